vector_memory_stage: RTL

VECTOR_MEMORY_STAGE -- requirements
Module: vector_memory_stage

---
 rtl/vector_memory_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vector_memory_stage.sv
// Vector memory stage: pass-through or per-lane sequential load/store.
// Optional macro VMEM_STRIDE_EN selects the latched stride as lane step.
module vector_memory_stage #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int TW    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                E_VALID,
    output logic                E_READY,
    input  logic [1:0]          E_OP,
    input  logic [AW-1:0]       E_ADDR,
    input  logic [AW-1:0]       E_STRIDE,
    input  logic [LANES*DW-1:0] E_ALU,
    input  logic [LANES*DW-1:0] E_WDATA,
    input  logic [TW-1:0]       E_TAG,
    output logic                MEM_REQ,
    output logic                MEM_WE,
    output logic [AW-1:0]       MEM_ADDR,
    output logic [DW-1:0]       MEM_WDATA,
    input  logic                MEM_ACK,
    input  logic [DW-1:0]       MEM_RDATA,
    output logic                M_VALID,
    output logic [LANES*DW-1:0] M_DATA,
    output logic [TW-1:0]       M_TAG,
    output logic                M_WB
);

    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [KW-1:0]       r_k;
    logic                r_store;
    logic [AW-1:0]       r_addr;
    logic [LANES*DW-1:0] r_wdata;
    logic [LANES*DW-1:0] r_res;
    logic [TW-1:0]       r_tag;
    logic                r_mvalid;
    logic [LANES*DW-1:0] r_mdata;
    logic [TW-1:0]       r_mtag;
    logic                r_mwb;

    logic                w_access;
    logic                w_accept;
    logic                w_is_mem;
    logic                w_last;
    logic [AW-1:0]       w_step;
    logic [DW-1:0]       w_lane_wd;
    logic [LANES*DW-1:0] w_gather;

`ifdef VMEM_STRIDE_EN
    logic [AW-1:0]       r_stride;
    assign w_step = r_stride;
`else
    logic                w_unused_stride;
    assign w_step = AW'(DW / 8);
    assign w_unused_stride = ^E_STRIDE;
`endif

    assign w_access  = (r_state == S_ACCESS);
    assign w_accept  = E_VALID && (r_state == S_IDLE);
    assign w_is_mem  = ^E_OP;
    assign w_last    = (r_k == K_LAST);

    assign E_READY   = (r_state == S_IDLE);
    assign MEM_REQ   = w_access;
    assign MEM_WE    = w_access && r_store;
    assign MEM_ADDR  = w_access ? r_addr : '0;
    assign MEM_WDATA = w_access ? w_lane_wd : '0;

    assign M_VALID   = r_mvalid;
    assign M_DATA    = r_mdata;
    assign M_TAG     = r_mtag;
    assign M_WB      = r_mwb;

    // Result including the lane being acknowledged this cycle.
    always_comb begin
        w_gather = r_res;
        w_gather[r_k*DW +: DW] = MEM_RDATA;
        w_lane_wd = r_wdata[r_k*DW +: DW];
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (E_VALID && w_is_mem) w_next = S_ACCESS;
            S_ACCESS: if (MEM_ACK && w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_k      <= '0;
            r_store  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_res    <= '0;
            r_tag    <= '0;
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_mtag   <= '0;
            r_mwb    <= 1'b0;
`ifdef VMEM_STRIDE_EN
            r_stride <= '0;
`endif
        end else begin
            r_mvalid <= 1'b0;
            if (w_accept && w_is_mem) begin
                r_store <= (E_OP == 2'b10);
                r_addr  <= E_ADDR;
                r_wdata <= E_WDATA;
                r_tag   <= E_TAG;
                r_k     <= '0;
                r_res   <= '0;
`ifdef VMEM_STRIDE_EN
                r_stride <= E_STRIDE;
`endif
            end else if (w_accept) begin
                r_mvalid <= 1'b1;
                r_mdata  <= E_ALU;
                r_mtag   <= E_TAG;
                r_mwb    <= 1'b1;
            end else if (w_access && MEM_ACK) begin
                if (!r_store) r_res <= w_gather;
                r_addr <= r_addr + w_step;
                if (w_last) begin
                    r_mvalid <= 1'b1;
                    r_mtag   <= r_tag;
                    r_mwb    <= !r_store;
                    r_mdata  <= r_store ? '0 : w_gather;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

endmodule
